// File: rtl/jtag_tap_datapath.sv
// rtl/jtag_tap_datapath.sv - JTAG TAP instruction/data register datapath with TDO mux
module jtag_tap_datapath #(
  parameter int          IR_WIDTH     = 4,
  parameter int          BSR_WIDTH    = 8,
  parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001
) (
  input  logic                 TCK,
  input  logic                 TRST,
  input  logic [3:0]           state,
  input  logic                 TDI,
  input  logic [BSR_WIDTH-1:0] pin_in,
  output logic                 TDO,
  output logic                 TDO_en,
  output logic [BSR_WIDTH-1:0] bsr_out,
  output logic                 extest,
  output logic [IR_WIDTH-1:0]  ir_out
);

  // TAP state codes shared with the controller FSM
  localparam logic [3:0] ST_TLR        = 4'd0;
  localparam logic [3:0] ST_CAPTURE_DR = 4'd3;
  localparam logic [3:0] ST_SHIFT_DR   = 4'd4;
  localparam logic [3:0] ST_UPDATE_DR  = 4'd8;
  localparam logic [3:0] ST_CAPTURE_IR = 4'd10;
  localparam logic [3:0] ST_SHIFT_IR   = 4'd11;
  localparam logic [3:0] ST_UPDATE_IR  = 4'd15;

  // Instruction codes; any code not listed acts as BYPASS
  localparam logic [IR_WIDTH-1:0] IR_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(2);
  // Capture-IR pattern: low two bits 01 so a scan chain can be sized by the host
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0]  ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0]  ir_q, ir_d;
  logic                 bypass_q, bypass_d;
  logic [31:0]          id_shift_q, id_shift_d;
  logic [BSR_WIDTH-1:0] bsr_shift_q, bsr_shift_d;
  logic [BSR_WIDTH-1:0] bsr_q, bsr_d;
  logic                 tdo_q, tdo_d;
  logic                 tdo_en_q, tdo_en_d;

  logic sel_idcode;
  logic sel_bsr;

  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_bsr    = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);

  assign ir_out  = ir_q;
  assign bsr_out = bsr_q;
  assign extest  = (ir_q == IR_EXTEST);
  assign TDO     = tdo_q;
  assign TDO_en  = tdo_en_q;

  // Next-state for IR and data registers; only the register chosen by the IR latch moves
  always_comb begin
    ir_shift_d  = ir_shift_q;
    ir_d        = ir_q;
    bypass_d    = bypass_q;
    id_shift_d  = id_shift_q;
    bsr_shift_d = bsr_shift_q;
    bsr_d       = bsr_q;
    case (state)
      ST_TLR:        ir_d       = IR_IDCODE;
      ST_CAPTURE_IR: ir_shift_d = IR_CAPTURE;
      ST_SHIFT_IR:   ir_shift_d = IR_WIDTH'({TDI, ir_shift_q} >> 1);
      ST_UPDATE_IR:  ir_d       = ir_shift_q;
      ST_CAPTURE_DR: begin
        if (sel_bsr)         bsr_shift_d = pin_in;
        else if (sel_idcode) id_shift_d  = IDCODE_VALUE;
        else                 bypass_d    = 1'b0;
      end
      ST_SHIFT_DR: begin
        if (sel_bsr)         bsr_shift_d = BSR_WIDTH'({TDI, bsr_shift_q} >> 1);
        else if (sel_idcode) id_shift_d  = {TDI, id_shift_q[31:1]};
        else                 bypass_d    = TDI;
      end
      ST_UPDATE_DR: begin
        if (sel_bsr) bsr_d = bsr_shift_q;
      end
      default: ;
    endcase
  end

  // Rising-edge register update; TRST forces the power-on image immediately
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift_q  <= IR_CAPTURE;
      ir_q        <= IR_IDCODE;
      bypass_q    <= 1'b0;
      id_shift_q  <= IDCODE_VALUE;
      bsr_shift_q <= '0;
      bsr_q       <= '0;
    end else begin
      ir_shift_q  <= ir_shift_d;
      ir_q        <= ir_d;
      bypass_q    <= bypass_d;
      id_shift_q  <= id_shift_d;
      bsr_shift_q <= bsr_shift_d;
      bsr_q       <= bsr_d;
    end
  end

  // TDO source select: LSB of whichever register is currently shifting
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state == ST_SHIFT_IR) begin
      tdo_d    = ir_shift_q[0];
      tdo_en_d = 1'b1;
    end else if (state == ST_SHIFT_DR) begin
      tdo_en_d = 1'b1;
      if (sel_bsr)         tdo_d = bsr_shift_q[0];
      else if (sel_idcode) tdo_d = id_shift_q[0];
      else                 tdo_d = bypass_q;
    end
  end

  // TDO launched on the falling edge so it is stable at the next rising edge
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

endmodule

// File: tb/tb_jtag_tap_datapath.sv
// tb/tb_jtag_tap_datapath.sv - directed self-checking bench for jtag_tap_datapath
module tb_jtag_tap_datapath;

  logic       TCK;
  logic       TRST;
  logic [3:0] state;
  logic       TDI;
  logic [7:0] pin_in;
  logic       TDO;
  logic       TDO_en;
  logic [7:0] bsr_out;
  logic       extest;
  logic [3:0] ir_out;

  int n_tests;
  int n_fail;

  logic        tdo_s;
  logic        en_s;
  logic [31:0] dout;
  logic        en_all;

  jtag_tap_datapath #(
    .IR_WIDTH    (4),
    .BSR_WIDTH   (8),
    .IDCODE_VALUE(32'h1234_5001)
  ) dut (
    .TCK    (TCK),
    .TRST   (TRST),
    .state  (state),
    .TDI    (TDI),
    .pin_in (pin_in),
    .TDO    (TDO),
    .TDO_en (TDO_en),
    .bsr_out(bsr_out),
    .extest (extest),
    .ir_out (ir_out)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One TCK cycle in the given state; TDO/TDO_en sampled after the falling edge
  task automatic step(input logic [3:0] st, input logic tdi);
    state = st;
    TDI   = tdi;
    @(negedge TCK);
    #1;
    tdo_s = TDO;
    en_s  = TDO_en;
    @(posedge TCK);
    #1;
  endtask

  // n cycles in a shift state, TDI from din LSB first, TDO collected into dout
  task automatic shift(input logic [3:0] st, input int n, input logic [31:0] din);
    dout   = '0;
    en_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      step(st, din[i]);
      dout[i] = tdo_s;
      en_all  = en_all & en_s;
    end
  endtask

  task automatic load_ir(input logic [3:0] code);
    step(4'd2, 1'b0);
    step(4'd9, 1'b0);
    step(4'd10, 1'b0);
    shift(4'd11, 4, {28'd0, code});
    step(4'd12, 1'b0);
    step(4'd15, 1'b0);
    step(4'd1, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    TRST    = 1'b1;
    state   = 4'd0;
    TDI     = 1'b0;
    pin_in  = 8'h00;
    #2;
    chk("rst_ir_out", 32'(ir_out), 32'h1);
    chk("rst_tdo", 32'(TDO), 32'h0);
    chk("rst_tdo_en", 32'(TDO_en), 32'h0);
    chk("rst_bsr_out", 32'(bsr_out), 32'h0);
    chk("rst_extest", 32'(extest), 32'h0);
    @(posedge TCK);
    #1;
    TRST = 1'b0;
    step(4'd0, 1'b0);
    step(4'd1, 1'b0);

    // IDCODE read with a pause after 4 bits
    step(4'd2, 1'b0);
    step(4'd3, 1'b0);
    chk("capture_dr_en", 32'(en_s), 32'h0);
    shift(4'd4, 4, 32'h0);
    chk("id_first4", dout, 32'h1);
    chk("id_first4_en", 32'(en_all), 32'h1);
    step(4'd5, 1'b0);
    step(4'd6, 1'b0);
    chk("pause_en", 32'(en_s), 32'h0);
    step(4'd6, 1'b0);
    step(4'd6, 1'b0);
    step(4'd7, 1'b0);
    shift(4'd4, 28, 32'h0);
    chk("id_rest28", dout, 32'h0123_4500);
    chk("id_rest28_en", 32'(en_all), 32'h1);
    step(4'd5, 1'b0);
    step(4'd8, 1'b0);
    step(4'd1, 1'b0);

    // Plain 32-bit IDCODE read
    step(4'd2, 1'b0);
    step(4'd3, 1'b0);
    shift(4'd4, 32, 32'hFFFF_FFFF);
    chk("id_full", dout, 32'h1234_5001);
    step(4'd5, 1'b0);
    step(4'd8, 1'b0);
    step(4'd1, 1'b0);
    chk("idle_en", 32'(en_s), 32'h0);

    // IR load of all ones, captured 0001 comes out first
    step(4'd2, 1'b0);
    step(4'd9, 1'b0);
    step(4'd10, 1'b0);
    shift(4'd11, 4, 32'hF);
    chk("ir_capture_tdo", dout, 32'h1);
    chk("ir_shift_en", 32'(en_all), 32'h1);
    step(4'd12, 1'b0);
    step(4'd15, 1'b0);
    chk("ir_out_bypass", 32'(ir_out), 32'hF);
    step(4'd1, 1'b0);

    // BYPASS: TDI 1,0,1,1,0 -> TDO 0,1,0,1,1
    step(4'd2, 1'b0);
    step(4'd3, 1'b0);
    shift(4'd4, 5, 32'h0D);
    chk("bypass_tdo", dout, 32'h1A);
    step(4'd5, 1'b0);
    step(4'd8, 1'b0);
    step(4'd1, 1'b0);
    chk("bypass_bsr_hold", 32'(bsr_out), 32'h0);

    // EXTEST: capture A5, shift in 3C
    load_ir(4'h0);
    chk("extest_ir", 32'(ir_out), 32'h0);
    chk("extest_flag", 32'(extest), 32'h1);
    pin_in = 8'hA5;
    step(4'd2, 1'b0);
    step(4'd3, 1'b0);
    shift(4'd4, 8, 32'h3C);
    chk("extest_tdo", dout, 32'hA5);
    step(4'd5, 1'b0);
    chk("extest_pre_update", 32'(bsr_out), 32'h0);
    step(4'd8, 1'b0);
    chk("extest_bsr_out", 32'(bsr_out), 32'h3C);
    chk("extest_flag2", 32'(extest), 32'h1);
    step(4'd1, 1'b0);

    // SAMPLE: capture 5A, shift in FF
    load_ir(4'h2);
    chk("sample_extest", 32'(extest), 32'h0);
    pin_in = 8'h5A;
    step(4'd2, 1'b0);
    step(4'd3, 1'b0);
    shift(4'd4, 8, 32'hFF);
    chk("sample_tdo", dout, 32'h5A);
    step(4'd5, 1'b0);
    step(4'd8, 1'b0);
    chk("sample_bsr_out", 32'(bsr_out), 32'hFF);
    step(4'd1, 1'b0);

    // IR overshift: 8 bits through a 4-bit IR, unknown code C then acts as BYPASS
    step(4'd2, 1'b0);
    step(4'd9, 1'b0);
    step(4'd10, 1'b0);
    shift(4'd11, 8, 32'hCA);
    chk("ir_overshift_tdo", dout, 32'hA1);
    step(4'd12, 1'b0);
    step(4'd15, 1'b0);
    chk("ir_out_unknown", 32'(ir_out), 32'hC);
    step(4'd1, 1'b0);
    step(4'd2, 1'b0);
    step(4'd3, 1'b0);
    shift(4'd4, 2, 32'h3);
    chk("unknown_bypass_tdo", dout, 32'h2);
    step(4'd5, 1'b0);
    step(4'd8, 1'b0);
    chk("unknown_bsr_hold", 32'(bsr_out), 32'hFF);
    step(4'd1, 1'b0);

    // TRST mid-shift under EXTEST aborts without update, no TCK edge needed
    load_ir(4'h0);
    pin_in = 8'hC3;
    step(4'd2, 1'b0);
    step(4'd3, 1'b0);
    shift(4'd4, 3, 32'h7);
    TRST = 1'b1;
    #1;
    chk("abort_bsr_out", 32'(bsr_out), 32'h0);
    chk("abort_ir_out", 32'(ir_out), 32'h1);
    chk("abort_extest", 32'(extest), 32'h0);
    chk("abort_tdo", 32'(TDO), 32'h0);
    chk("abort_tdo_en", 32'(TDO_en), 32'h0);
    #1;
    TRST = 1'b0;
    step(4'd0, 1'b0);
    step(4'd1, 1'b0);
    chk("post_abort_bsr", 32'(bsr_out), 32'h0);
    chk("post_abort_ir", 32'(ir_out), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
